reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_READ, default 3: number of independent read ports, minimum 1.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes and marks.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port rstN  input  1: reset, synchronous, active-low.
REQ-007 Port readAddr  input  NUM_READ*ADDR_WIDTH: read addresses; port k uses slice k.
REQ-008 Port readEn  input  NUM_READ: read port k is in use (qualifies hazard only).
REQ-009 Port readData  output  NUM_READ*DATA_WIDTH: read data; port k uses slice k.
REQ-010 Port readBusy  output  NUM_READ: addressed register of port k is pending.
REQ-011 Port hazard  output  1: OR over k of (readEn[k] AND readBusy[k]).
REQ-012 Port writeEnA, writeAddrA, writeDataA  input  1/ADDR_WIDTH/DATA_WIDTH: ALU writeback port.
REQ-013 Port writeEnB, writeAddrB, writeDataB  input  1/ADDR_WIDTH/DATA_WIDTH: load writeback port; also clears busy.
REQ-014 Port markEn, markAddr  input  1/ADDR_WIDTH: set the busy bit of markAddr (load issued).
REQ-015 Port busyCount  output  ADDR_WIDTH+1: number of registers currently busy.

Function
REQ-016 Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus one busy bit per register, all written on rising clk.
REQ-017 Read path: combinational, zero latency, each port independent; any port may read any address, including the same address.
REQ-018 Write-through bypass: if an enabled write this cycle targets a read port's address, readData shows that write data in the same cycle; B takes priority over A.
REQ-019 Write collision: writeEnA and writeEnB to the same address in one cycle stores writeDataB; A is dropped.
REQ-020 Busy set: markEn sets busy[markAddr] at the next edge.
REQ-021 Busy clear: writeEnB clears busy[writeAddrB] at the next edge; writeEnA never changes busy bits.
REQ-022 Simultaneous mark and writeEnB on the same address: the register is written AND remains busy (mark wins).
REQ-023 Busy bypass: readBusy[k] is 0 in the same cycle that writeEnB clears that address unless REQ-022 applies; markEn is not bypassed (busy visible the cycle after the mark).
REQ-024 busyCount equals the population count of busy bits after each edge; updates by -1, 0 or +1 per cycle; never exceeds 2**ADDR_WIDTH.
REQ-025 Marking an already-busy register leaves busyCount unchanged; clearing a non-busy register leaves it unchanged.
REQ-026 ZERO_REG=1: address 0 always reads 0, readBusy 0, write/mark to address 0 ignored, never bypassed, never counted.
REQ-027 ZERO_REG=0: register 0 behaves as every other register.

Reset
REQ-028 rstN low at a rising edge: all registers 0, all busy bits 0, busyCount 0.
REQ-029 While rstN is low, writes, marks and bypass are ignored; readData shows the stored array; readBusy and hazard are 0.
REQ-030 Reset mid-operation discards all pending busy state; no write from that cycle survives.
REQ-031 Power-up state before the first reset edge is undefined; outputs are valid only after the first rstN-low edge.

Verification
REQ-032 Reset, read all addresses on 3 ports -> readData 0, readBusy 0, busyCount 0, hazard 0.
REQ-033 writeEnA addr 5 data 0x1234_5678, readAddr port0 = 5 same cycle -> readData0 = 0x12345678 before the edge and after it.
REQ-034 Same cycle: A writes addr 7 = 0xAAAA_AAAA, B writes addr 7 = 0x5555_5555 -> reads 0x55555555 same cycle and thereafter.
REQ-035 markEn addr 9; next cycle readEn0=1, readAddr0=9 -> readBusy0=1, hazard=1, busyCount=1; writeEnB addr 9 data 0xDEAD_BEEF -> same cycle readBusy0=0, hazard=0, readData0=0xDEADBEEF; next cycle busyCount=0.
REQ-036 markEn and writeEnB both addr 3 in one cycle -> reg 3 updated, busy[3]=1, busyCount +1; mark addr 0 and write 0xFFFF_FFFF to addr 0 -> reads 0, busyCount unchanged.
REQ-037 Mark addrs 1, 2, 4, then assert rstN low for one edge -> busyCount 0, all registers 0, hazard 0.

Source files
------------

// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if
//   Bundles the read, writeback, mark and status signals of the register
//   file scoreboard.
//   master : the pipeline side (drives addresses, writes, marks).
//   slave  : the register file (drives read data, busy flags, hazard, count).
//   Widths follow DATA_WIDTH / ADDR_WIDTH / NUM_READ.
interface reg_file_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 3
);
    logic [NUM_READ*ADDR_WIDTH-1:0] readAddr;
    logic [NUM_READ-1:0]            readEn;
    logic [NUM_READ*DATA_WIDTH-1:0] readData;
    logic [NUM_READ-1:0]            readBusy;
    logic                           hazard;

    logic                           writeEnA;
    logic [ADDR_WIDTH-1:0]          writeAddrA;
    logic [DATA_WIDTH-1:0]          writeDataA;

    logic                           writeEnB;
    logic [ADDR_WIDTH-1:0]          writeAddrB;
    logic [DATA_WIDTH-1:0]          writeDataB;

    logic                           markEn;
    logic [ADDR_WIDTH-1:0]          markAddr;

    logic [ADDR_WIDTH:0]            busyCount;

    modport master (
        output readAddr, readEn,
        output writeEnA, writeAddrA, writeDataA,
        output writeEnB, writeAddrB, writeDataB,
        output markEn, markAddr,
        input  readData, readBusy, hazard, busyCount
    );

    modport slave (
        input  readAddr, readEn,
        input  writeEnA, writeAddrA, writeDataA,
        input  writeEnB, writeAddrB, writeDataB,
        input  markEn, markAddr,
        output readData, readBusy, hazard, busyCount
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Multi-ported register file with a per-register busy (scoreboard) bit.
//   Ports:
//     clk   : rising-edge clock
//     rstN  : synchronous active-low reset (clears array, busy bits, count)
//     bus   : reg_file_scoreboard_if.slave
//             readAddr/readEn -> readData/readBusy/hazard (combinational)
//             writeEnA/.. : ALU writeback
//             writeEnB/.. : load writeback, clears busy, wins over A
//             markEn/..   : sets busy at the next edge (load issued)
//             busyCount   : number of busy registers
//   ZERO_REG=1 hard-wires register 0 to zero and keeps it out of the
//   scoreboard.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 3,
    parameter int ZERO_REG   = 1
) (
    input logic                  clk,
    input logic                  rstN,
    reg_file_scoreboard_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busyCount_q;
    logic [ADDR_WIDTH:0]   busyCount_d;

    logic wrA;
    logic wrB;
    logic mark;
    logic keepA;

    logic [NUM_READ*DATA_WIDTH-1:0] rdata;
    logic [NUM_READ-1:0]            rbusy;
    logic [ADDR_WIDTH-1:0]          ra;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Qualified write/mark strobes: gated by reset and the zero register.
    always_comb begin
        wrA   = rstN && bus.writeEnA && !is_zero(bus.writeAddrA);
        wrB   = rstN && bus.writeEnB && !is_zero(bus.writeAddrB);
        mark  = rstN && bus.markEn   && !is_zero(bus.markAddr);
        keepA = wrA && !(wrB && (bus.writeAddrA == bus.writeAddrB));
    end

    // Clear from B is applied before the mark so a same-address mark wins.
    always_comb begin
        busy_d = busy_q;
        if (wrB) begin
            busy_d[bus.writeAddrB] = 1'b0;
        end
        if (mark) begin
            busy_d[bus.markAddr] = 1'b1;
        end
        busyCount_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busyCount_d = busyCount_d + (ADDR_WIDTH+1)'(busy_d[ADDR_WIDTH'(i)]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_WIDTH'(i)] <= '0;
            end
            busy_q      <= '0;
            busyCount_q <= '0;
        end else begin
            if (keepA) begin
                mem_q[bus.writeAddrA] <= bus.writeDataA;
            end
            if (wrB) begin
                mem_q[bus.writeAddrB] <= bus.writeDataB;
            end
            busy_q      <= busy_d;
            busyCount_q <= busyCount_d;
        end
    end

    // Read ports: write-through bypass (B over A), and the busy flag drops in
    // the same cycle a load writeback clears it unless a mark re-arms it.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            ra = bus.readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (is_zero(ra)) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy[k] = 1'b0;
            end else begin
                if (wrB && (bus.writeAddrB == ra)) begin
                    rdata[k*DATA_WIDTH +: DATA_WIDTH] = bus.writeDataB;
                end else if (wrA && (bus.writeAddrA == ra)) begin
                    rdata[k*DATA_WIDTH +: DATA_WIDTH] = bus.writeDataA;
                end else begin
                    rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
                end
                rbusy[k] = rstN && busy_q[ra]
                           && !(wrB && (bus.writeAddrB == ra)
                                && !(mark && (bus.markAddr == ra)));
            end
        end
    end

    always_comb begin
        bus.readData  = rdata;
        bus.readBusy  = rbusy;
        bus.hazard    = |(bus.readEn & rbusy);
        bus.busyCount = busyCount_q;
    end
endmodule
